bandai_mapper_gen2: RTL

//  Parametrised cartridge mapper controller: console bus address-unlock sequencer,

---
 rtl/bandai_mapper_gen2_if.sv | 22 ++
 rtl/bandai_mapper_gen2.sv | 114 +++++++++++
 2 files changed

// File: rtl/bandai_mapper_gen2_if.sv
// bandai_mapper_gen2_if: cartridge-edge bus between the console side
// (master) and the mapper (slave).
interface bandai_mapper_gen2_if;
    logic       CEn;
    logic       SSn;
    logic       OEn;
    logic       WEn;
    logic [7:0] ADDR;
    logic [7:0] DQ_I;
    logic [7:0] DQ_O;
    logic       DQ_OE;

    modport master (
        output CEn, SSn, OEn, WEn, ADDR, DQ_I,
        input  DQ_O, DQ_OE
    );

    modport slave (
        input  CEn, SSn, OEn, WEn, ADDR, DQ_I,
        output DQ_O, DQ_OE
    );
endinterface

// File: rtl/bandai_mapper_gen2.sv
// bandai_mapper_gen2: cartridge mapper with an address-unlock sequencer,
// serial bitstream emitter on SO and a bank-register file.
module bandai_mapper_gen2 #(
    parameter int                UNLOCK_LEN = 2,
    parameter logic [63:0]       UNLOCK_SEQ = 64'hA55A,
    parameter int                BS_LEN     = 18,
    parameter logic [BS_LEN-1:0] BS         = 18'h05140,
    parameter int                NUM_BANKS  = 4,
    parameter logic [7:0]        BANK_BASE  = 8'hC0,
    parameter bit                STRICT     = 1'b0
) (
    input  logic                   CLK,
    input  logic                   RSTn,
    bandai_mapper_gen2_if.slave    bus,
    output logic                   SO,
    output logic                   UNLOCKED,
    output logic [8*NUM_BANKS-1:0] BANKS
);
    localparam int BW = $clog2(NUM_BANKS);

    typedef logic [NUM_BANKS-1:0][7:0] bank_t;

    logic [3:0]        idx_q, idx_d;
    logic              unlocked_q, unlocked_d;
    logic [BS_LEN-1:0] sr_q, sr_d;
    bank_t             bank_q, bank_d;

    logic [7:0]    seq_cur;
    logic [7:0]    seq_prev;
    logic          sel;
    logic          in_win;
    logic          rd;
    logic          wr;
    logic          relock;
    logic          last_step;
    logic [8:0]    off;
    logic [BW-1:0] bidx;

    // 9-bit offset: addresses below the base wrap far outside the window.
    assign sel    = ~(bus.SSn & bus.CEn);
    assign off    = {1'b0, bus.ADDR} - {1'b0, BANK_BASE};
    assign bidx   = off[BW-1:0];
    assign in_win = sel & (off < 9'(NUM_BANKS));
    assign rd     = in_win & ~bus.OEn & bus.WEn;
    assign wr     = in_win & bus.OEn & ~bus.WEn;

    // Relock address sits one past the last bank register.
    assign relock = unlocked_q & sel
                  & bus.OEn & ~bus.WEn
                  & (off == 9'(NUM_BANKS))
                  & (bus.DQ_I == 8'h00);

    always_comb begin
        seq_cur  = 8'h00;
        seq_prev = 8'h00;
        for (int i = 0; i < UNLOCK_LEN; i++) begin
            if (idx_q == 4'(i)) begin
                seq_cur = UNLOCK_SEQ[8*i +: 8];
            end
            if (idx_q == 4'(i + 1)) begin
                seq_prev = UNLOCK_SEQ[8*i +: 8];
            end
        end
    end

    assign last_step = (idx_q == 4'(UNLOCK_LEN - 1));

    always_comb begin
        idx_d      = idx_q;
        unlocked_d = unlocked_q;
        sr_d       = {1'b1, sr_q[BS_LEN-1:1]};
        bank_d     = bank_q;
        if (!unlocked_q) begin
            if (bus.ADDR == seq_cur) begin
                idx_d = idx_q + 4'd1;
                if (last_step) begin
                    sr_d       = BS;
                    unlocked_d = 1'b1;
                end
            end else if (STRICT && (idx_q != 4'd0)
                         && (bus.ADDR != seq_prev)) begin
                idx_d = 4'd0;
            end
        end else begin
            if (relock) begin
                unlocked_d = 1'b0;
                idx_d      = 4'd0;
            end
            if (wr) begin
                bank_d[bidx] = bus.DQ_I;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            idx_q      <= '0;
            unlocked_q <= 1'b0;
            sr_q       <= '1;
            bank_q     <= '1;
        end else begin
            idx_q      <= idx_d;
            unlocked_q <= unlocked_d;
            sr_q       <= sr_d;
            bank_q     <= bank_d;
        end
    end

    assign UNLOCKED  = unlocked_q;
    assign BANKS     = bank_q;
    assign bus.DQ_OE = unlocked_q & rd;
    assign bus.DQ_O  = (unlocked_q & rd) ? bank_q[bidx] : 8'h00;
    assign SO        = RSTn ? sr_q[0] : 1'bz;
endmodule
